serial_addsub: RTL and testbench

Bit-serial N-bit adder/subtractor controller. It drives the existing single-bit `fas` cell: each clock it presents one LSB-first operand bit pair plus the registered carry/borrow, then captures `s` and `cout`. It sits directly upstream of `fas` and also consumes its output. It provides a start/busy/done handshake and registered result, carry/borrow and signed-overflow flags.

---
 rtl/serial_addsub_pkg.sv | 9 +
 rtl/serial_addsub_fas.sv | 23 ++
 rtl/serial_addsub.sv | 120 ++++++++++++
 tb/tb_serial_addsub.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and mode encodings for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic ADD = 1'b1;
  localparam logic SUB = 1'b0;

endpackage

// File: rtl/serial_addsub_fas.sv
// Single-bit full adder/subtractor cell; cout is carry (add) or borrow (subtract).
module fas
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = 1'b0;
    case (a_ns)
      ADD:     cout = (a & b) | (cin & (a ^ b));
      SUB:     cout = (~a & b) | (cin & ~(a ^ b));
      default: ;
    endcase
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit add/subtract controller around one fas cell, LSB first,
// with start/busy/done handshake and registered result, carry/borrow and overflow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         a_ns,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned CntW = $clog2(N);

  state_t         state_q, state_d;
  logic [N-1:0]   a_sh_q, a_sh_d;
  logic [N-1:0]   b_sh_q, b_sh_d;
  logic [N-1:0]   r_sh_q, r_sh_d;
  logic [N-1:0]   result_q, result_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic fas_s;
  logic fas_cout;

  fas u_fas (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .a_ns (mode_q),
    .s    (fas_s),
    .cout (fas_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = a_ns;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        r_sh_d  = {fas_s, r_sh_q[N-1:1]};
        carry_d = fas_cout;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) begin
          result_d = {fas_s, r_sh_q[N-1:1]};
          cout_d   = fas_cout;
          // carry into the MSB differs from carry out of it exactly on signed overflow
          ovf_d    = carry_q ^ fas_cout;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: arithmetic reference model feeds a queue,
// a negedge monitor checks every output cycle by cycle.
module tb_serial_addsub;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         a_ns = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  logic         ovf;

  always #50 clk = ~clk;

  serial_addsub #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_ns   (a_ns),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  typedef struct {
    logic [N-1:0] res;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails = 0;
  int edge_cnt = 0;
  int acc_cnt = 0;
  int rst_cnt = 0;
  int run_left = 0;
  bit m_done = 1'b0;

  // Plain integer arithmetic: unsigned for result/carry/borrow, signed range for overflow.
  function automatic exp_t ref_op(input logic [N-1:0] x, input logic [N-1:0] y,
                                  input logic add, input int e);
    exp_t r;
    int xu, yu, xs, ys, rs, ru;
    xu = int'(x);
    yu = int'(y);
    xs = x[N-1] ? xu - (1 << N) : xu;
    ys = y[N-1] ? yu - (1 << N) : yu;
    if (add) begin
      ru = xu + yu;
      rs = xs + ys;
      r.co = (ru >= (1 << N));
    end else begin
      ru = xu - yu;
      rs = xs - ys;
      r.co = (xu < yu);
    end
    r.res = N'(ru);
    r.ov  = (rs > (1 << (N - 1)) - 1) || (rs < -(1 << (N - 1)));
    r.acc = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Reference timing: accept when free, N edges of run, one done cycle.
  initial forever begin
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      run_left = 0;
      m_done   = 1'b0;
      rst_cnt++;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (run_left > 0) begin
      run_left--;
      if (run_left == 0) m_done = 1'b1;
    end else if (start) begin
      q.push_back(ref_op(a, b, a_ns, edge_cnt));
      acc_cnt++;
      run_left = N;
    end
  end

  initial begin : monitor
    int seen_rst;
    exp_t last;
    exp_t e;
    seen_rst = 0;
    last = '{res: '0, co: 1'b0, ov: 1'b0, acc: 0};
    forever begin
      @(negedge clk);
      if (rst_cnt != seen_rst) begin
        seen_rst = rst_cnt;
        q.delete();
        last = '{res: '0, co: 1'b0, ov: 1'b0, acc: 0};
      end
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL done_unexpected: got done=1 expected no pending op (edge %0d)",
                   edge_cnt);
        end else begin
          e = q.pop_front();
          chk("latency", 32'(edge_cnt - e.acc), 32'(N));
          last = e;
        end
      end
      chk("busy", 32'(busy), 32'(run_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("result", 32'(result), 32'(last.res));
      chk("cout", 32'(cout), 32'(last.co));
      chk("ovf", 32'(ovf), 32'(last.ov));
    end
  end

  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic md,
                       input bit keep);
    int old;
    int n;
    @(negedge clk);
    a = x;
    b = y;
    a_ns = md;
    start = 1'b1;
    old = acc_cnt;
    n = 0;
    while (acc_cnt == old && n < 4 * N) begin
      @(negedge clk);
      n++;
    end
    if (!keep) start = 1'b0;
    checks++;
    if (acc_cnt == old) begin
      fails++;
      $display("FAIL accept_timeout: got no accept expected accept within %0d cycles", 4 * N);
    end
  endtask

  task automatic wait_idle();
    repeat (N + 3) @(negedge clk);
  endtask

  initial begin
    #(100 * 20000);
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'h3C, 8'h29, 1'b1, 1'b0); wait_idle();
    do_op(8'hFF, 8'h01, 1'b1, 1'b0); wait_idle();
    do_op(8'h7F, 8'h01, 1'b1, 1'b0); wait_idle();
    do_op(8'h05, 8'h07, 1'b0, 1'b0); wait_idle();
    do_op(8'h80, 8'h01, 1'b0, 1'b0); wait_idle();

    // start pulse mid-run must be ignored
    do_op(8'h10, 8'h20, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset mid-run: no done, outputs cleared
    do_op(8'h33, 8'h44, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h01, 8'h01, 1'b1, 1'b0); wait_idle();

    // start held high across three back-to-back ops
    do_op(8'h01, 8'h02, 1'b1, 1'b1);
    do_op(8'h0A, 8'h03, 1'b0, 1'b1);
    do_op(8'hF0, 8'h0F, 1'b1, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;
    repeat (2 * N) @(negedge clk);

    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_results: got %0d outstanding expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
